mc_control: RTL and testbench

- Multi-cycle control FSM for the single-cycle-shared MIPS datapath.
- Sequences the 32x32 register file (2 registered read ports, 1 write port), ALU, PC/IR latches and the unified memory port.
- Takes opcode/funct/dest fields from IR plus ALU zero and a memory ready handshake; emits all datapath strobes and selects.
- Counts retired instructions.

---
 rtl/mips_defs.sv | 63 ++++++
 rtl/mc_alu_decode.sv | 35 +++
 rtl/mc_control.sv | 185 ++++++++++++++++++
 tb/tb_mc_control.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, instruction
// fields, ALU operation codes and datapath mux selects.
package mips_defs;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_R_EXEC   = 4'd7,
        ST_R_WB     = 4'd8,
        ST_I_EXEC   = 4'd9,
        ST_I_WB     = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_HALT     = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // True in the last cycle of every legal instruction; memory stores finish
    // only when the memory accepts the write.
    function automatic logic completes(input state_e st, input logic mem_ready);
        case (st)
            ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: completes = 1'b1;
            ST_MEM_WR:                                     completes = mem_ready;
            default:                                       completes = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational instruction classifier: picks the execute-stage ALU operation
// from opcode/funct and flags encodings the control FSM cannot execute.
module mc_alu_decode
    import mips_defs::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_ctl,
    output logic       o_legal
);

    always_comb begin
        o_alu_ctl = ALU_ADD;
        o_legal   = 1'b1;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD:  o_alu_ctl = ALU_ADD;
                    FN_SUB:  o_alu_ctl = ALU_SUB;
                    FN_AND:  o_alu_ctl = ALU_AND;
                    FN_OR:   o_alu_ctl = ALU_OR;
                    FN_SLT:  o_alu_ctl = ALU_SLT;
                    default: o_legal   = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI: o_alu_ctl = ALU_ADD;
            OP_ANDI:               o_alu_ctl = ALU_AND;
            OP_ORI:                o_alu_ctl = ALU_OR;
            OP_BEQ, OP_BNE:        o_alu_ctl = ALU_SUB;
            OP_J:                  o_alu_ctl = ALU_ADD;
            default:               o_legal   = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode, execute, memory and
// write-back steps, drives all datapath strobes and counts retired instructions.
module mc_control
    import mips_defs::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctl,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       o_dbg_state
);

    // Memory handshake: mem_read/mem_write is a request held constant by the
    // FSM until the cycle in which mem_ready=1; that cycle completes the access.

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_retired;
    logic [3:0]       w_alu_ctl;
    logic             w_legal;
    logic             w_retire;

    mc_alu_decode u_alu_decode (
        .i_opcode  (opcode),
        .i_funct   (funct),
        .o_alu_ctl (w_alu_ctl),
        .o_legal   (w_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = ST_FETCH;
            ST_FETCH: if (mem_ready) w_next = ST_DECODE;
            ST_DECODE: begin
                if (!w_legal) begin
                    w_next = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
                end else begin
                    case (opcode)
                        OP_RTYPE:                w_next = ST_R_EXEC;
                        OP_LW, OP_SW:            w_next = ST_MEM_ADDR;
                        OP_ADDI, OP_ANDI, OP_ORI: w_next = ST_I_EXEC;
                        OP_BEQ, OP_BNE:          w_next = ST_BRANCH;
                        OP_J:                    w_next = ST_JUMP;
                        default:                 w_next = ST_HALT;
                    endcase
                end
            end
            ST_MEM_ADDR: w_next = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (mem_ready) w_next = ST_MEM_WB;
            ST_MEM_WR:   if (mem_ready) w_next = ST_FETCH;
            ST_MEM_WB:   w_next = ST_FETCH;
            ST_R_EXEC:   w_next = ST_R_WB;
            ST_R_WB:     w_next = ST_FETCH;
            ST_I_EXEC:   w_next = ST_I_WB;
            ST_I_WB:     w_next = ST_FETCH;
            ST_BRANCH:   w_next = ST_FETCH;
            ST_JUMP:     w_next = ST_FETCH;
            ST_HALT:     w_next = ST_HALT;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_ctl    = ALU_AND;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_ctl   = ALU_ADD;
                pc_source = PCSRC_ALU;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                alu_ctl   = ALU_ADD;
                illegal   = !w_legal;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_ctl   = ALU_ADD;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            // Writes aimed at $0 are dropped here; the instruction still retires.
            ST_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = (rt != 5'd0);
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_B;
                alu_ctl   = w_alu_ctl;
            end
            ST_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = (rd != 5'd0);
            end
            ST_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_ctl   = w_alu_ctl;
            end
            ST_I_WB:   reg_write = (rt != 5'd0);
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_B;
                alu_ctl   = ALU_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_write  = (opcode == OP_BNE) ? !zero : zero;
            end
            ST_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign w_retire = completes(r_state, mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign retired     = r_retired;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mc_control.sv
// Directed-vector bench for mc_control: each vector carries the stimulus for one
// cycle and the hand-derived state and strobe word expected in that cycle.
module tb_mc_control;
    import mips_defs::*;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       opcode = 6'h00;
    logic [5:0]       funct = 6'h00;
    logic [4:0]       rt = 5'd0;
    logic [4:0]       rd = 5'd0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0]       pc_source, alu_src_b;
    logic             alu_src_a, reg_dst, mem_to_reg, reg_write, illegal, halted;
    logic [3:0]       alu_ctl;
    logic [CNT_W-1:0] retired;
    logic [3:0]       o_dbg_state;

    mc_control #(.HALT_ON_ILLEGAL(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .rt(rt), .rd(rd),
        .zero(zero), .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal), .halted(halted),
        .retired(retired), .o_dbg_state(o_dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    logic [18:0] ctl_obs;
    assign ctl_obs = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source, alu_src_a,
                      alu_src_b, alu_ctl, reg_dst, mem_to_reg, reg_write, illegal, halted};

    int          n_cmp = 0;
    int          n_err = 0;
    logic [24:0] exp_q[$];   // {mem_ready, zero, state[3:0], ctl[18:0]}
    logic [18:0] c_idle, c_fetch, c_fetch_wait, c_decode, c_decode_ill, c_halt;

    function automatic logic [18:0] ctl(input logic mr, input logic mw, input logic iod,
                                        input logic irw, input logic pcw, input logic [1:0] pcs,
                                        input logic asa, input logic [1:0] asb, input logic [3:0] alu,
                                        input logic rdst, input logic m2r, input logic rw,
                                        input logic ill, input logic hlt);
        return {mr, mw, iod, irw, pcw, pcs, asa, asb, alu, rdst, m2r, rw, ill, hlt};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] t,
                          input logic [4:0] d);
        opcode = op; funct = fn; rt = t; rd = d;
    endtask

    task automatic push(input logic rdy, input logic z, input state_e st, input logic [18:0] c);
        exp_q.push_back({rdy, z, st, c});
    endtask

    task automatic push_fd();
        push(1'b1, 1'b0, ST_FETCH, c_fetch);
        push(1'b1, 1'b0, ST_DECODE, c_decode);
    endtask

    task automatic run_vecs(input string tag);
        logic [24:0] v;
        int          idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            mem_ready = v[24];
            zero      = v[23];
            #1;
            check_eq($sformatf("%s%0d_state", tag, idx), 32'(o_dbg_state), 32'(v[22:19]));
            check_eq($sformatf("%s%0d_ctl", tag, idx), 32'(ctl_obs), 32'(v[18:0]));
            @(posedge clk);
            #1;
            idx++;
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq({tag, "_state"}, 32'(o_dbg_state), 32'(ST_IDLE));
        check_eq({tag, "_ctl"}, 32'(ctl_obs), 32'(c_idle));
        check_eq({tag, "_retired"}, retired, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        c_idle       = '0;
        c_fetch      = ctl(1, 0, 0, 1, 1, 2'd0, 0, 2'd1, 4'd2, 0, 0, 0, 0, 0);
        c_fetch_wait = ctl(1, 0, 0, 0, 0, 2'd0, 0, 2'd1, 4'd2, 0, 0, 0, 0, 0);
        c_decode     = ctl(0, 0, 0, 0, 0, 2'd0, 0, 2'd3, 4'd2, 0, 0, 0, 0, 0);
        c_decode_ill = ctl(0, 0, 0, 0, 0, 2'd0, 0, 2'd3, 4'd2, 0, 0, 0, 1, 0);
        c_halt       = ctl(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 1);

        do_reset("rst0");

        // add $3,$1,$2
        set_ir(6'h00, 6'h20, 5'd2, 5'd3);
        push_fd();
        push(1, 0, ST_R_EXEC, ctl(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 4'd2, 0, 0, 0, 0, 0));
        push(1, 0, ST_R_WB,   ctl(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 4'd0, 1, 0, 1, 0, 0));
        run_vecs("add");
        check_eq("add_retired", retired, 32'd1);

        // sub $0,... : write suppressed, still retires
        set_ir(6'h00, 6'h22, 5'd2, 5'd0);
        push_fd();
        push(1, 0, ST_R_EXEC, ctl(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 4'd6, 0, 0, 0, 0, 0));
        push(1, 0, ST_R_WB,   ctl(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 4'd0, 1, 0, 0, 0, 0));
        run_vecs("sub0_");
        check_eq("sub0_retired", retired, 32'd2);

        // lw rt=5 with a fetch stall and 3 wait cycles in MEM_RD
        set_ir(6'h23, 6'h00, 5'd5, 5'd0);
        push(0, 0, ST_FETCH, c_fetch_wait);
        push_fd();
        push(1, 0, ST_MEM_ADDR, ctl(0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 4'd2, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            push((i == 3), 0, ST_MEM_RD, ctl(1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 0));
        push(1, 0, ST_MEM_WB, ctl(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 4'd0, 0, 1, 1, 0, 0));
        run_vecs("lw");
        check_eq("lw_retired", retired, 32'd3);

        // beq taken, beq not taken, bne taken
        set_ir(6'h04, 6'h00, 5'd1, 5'd0);
        push_fd();
        push(1, 1, ST_BRANCH, ctl(0, 0, 0, 0, 1, 2'd1, 1, 2'd0, 4'd6, 0, 0, 0, 0, 0));
        push_fd();
        push(1, 0, ST_BRANCH, ctl(0, 0, 0, 0, 0, 2'd1, 1, 2'd0, 4'd6, 0, 0, 0, 0, 0));
        run_vecs("beq");
        check_eq("beq_retired", retired, 32'd5);
        set_ir(6'h05, 6'h00, 5'd1, 5'd0);
        push_fd();
        push(1, 0, ST_BRANCH, ctl(0, 0, 0, 0, 1, 2'd1, 1, 2'd0, 4'd6, 0, 0, 0, 0, 0));
        run_vecs("bne");
        check_eq("bne_retired", retired, 32'd6);

        // addi rt=0: no register write, but retires
        set_ir(6'h08, 6'h00, 5'd0, 5'd0);
        push_fd();
        push(1, 0, ST_I_EXEC, ctl(0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 4'd2, 0, 0, 0, 0, 0));
        push(1, 0, ST_I_WB,   ctl(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 0));
        run_vecs("addi0_");
        check_eq("addi0_retired", retired, 32'd7);

        // ori rt=7
        set_ir(6'h0D, 6'h00, 5'd7, 5'd0);
        push_fd();
        push(1, 0, ST_I_EXEC, ctl(0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 4'd1, 0, 0, 0, 0, 0));
        push(1, 0, ST_I_WB,   ctl(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 4'd0, 0, 0, 1, 0, 0));
        run_vecs("ori");
        check_eq("ori_retired", retired, 32'd8);

        // j
        set_ir(6'h02, 6'h00, 5'd0, 5'd0);
        push_fd();
        push(1, 0, ST_JUMP, ctl(0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 4'd0, 0, 0, 0, 0, 0));
        run_vecs("j");
        check_eq("j_retired", retired, 32'd9);

        // sw stalled in MEM_WR, then reset asserted mid-access
        set_ir(6'h2B, 6'h00, 5'd4, 5'd0);
        push_fd();
        push(1, 0, ST_MEM_ADDR, ctl(0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 4'd2, 0, 0, 0, 0, 0));
        push(0, 0, ST_MEM_WR,   ctl(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 0));
        push(0, 0, ST_MEM_WR,   ctl(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 0));
        run_vecs("sw");
        check_eq("sw_pre_rst_retired", retired, 32'd9);
        rst_n = 1'b0;
        #1;
        check_eq("sw_async_state", 32'(o_dbg_state), 32'(ST_IDLE));
        check_eq("sw_async_mem_write", 32'(mem_write), 32'd0);
        check_eq("sw_async_retired", retired, 32'd0);
        do_reset("rst1");
        push(1, 0, ST_FETCH, c_fetch);
        run_vecs("post_rst");

        // add once more, then illegal opcode 0x3F parks in HALT
        set_ir(6'h00, 6'h20, 5'd2, 5'd3);
        push(1, 0, ST_DECODE, c_decode);
        push(1, 0, ST_R_EXEC, ctl(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 4'd2, 0, 0, 0, 0, 0));
        push(1, 0, ST_R_WB,   ctl(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 4'd0, 1, 0, 1, 0, 0));
        run_vecs("add2_");
        check_eq("add2_retired", retired, 32'd1);
        set_ir(6'h3F, 6'h00, 5'd0, 5'd0);
        push_fd();
        push(1, 0, ST_DECODE, c_decode_ill);
        for (int i = 0; i < 10; i++) push(1, 0, ST_HALT, c_halt);
        exp_q.delete(1);  // FETCH leads straight into the illegal DECODE
        run_vecs("illop");
        check_eq("illop_retired", retired, 32'd1);

        // R-type with an undecodable funct
        do_reset("rst2");
        set_ir(6'h00, 6'h3F, 5'd1, 5'd2);
        push(1, 0, ST_FETCH, c_fetch);
        push(1, 0, ST_DECODE, c_decode_ill);
        for (int i = 0; i < 3; i++) push(1, 0, ST_HALT, c_halt);
        run_vecs("illfn");
        check_eq("illfn_retired", retired, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
